// File: rtl/sw_capture_ctrl.sv
// Debounced push-button capture of the switch bank into a single-entry event
// register with a valid/ready handshake, event counter and sticky overrun flag.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | button released and debounced; waiting for a press
// ST_PRESS     | button seen high; counting stable-high cycles
// ST_CAPTURE   | one cycle; compare switches against last capture, load/drop
// ST_RELEASE   | waiting for the button to be stably low before re-arming
module sw_capture_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SW_W            = 10,
  parameter int CNT_W           = 8
) (
  input  logic             clk_50m,
  input  logic             rst_n_i,
  input  logic [SW_W-1:0]  sw_i,
  input  logic             btn_i,
  output logic [SW_W-1:0]  evt_data_o,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [CNT_W-1:0] evt_cnt_o,
  output logic             busy_o,
  output logic             overrun_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESS   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  // Two-flop synchronizers for the asynchronous board inputs
  logic            btn_meta_q, btn_meta_d;
  logic            btn_s_q,    btn_s_d;
  logic [SW_W-1:0] sw_meta_q,  sw_meta_d;
  logic [SW_W-1:0] sw_s_q,     sw_s_d;

  logic [1:0]       state_q,   state_d;
  logic [DB_W-1:0]  db_cnt_q,  db_cnt_d;
  logic [SW_W-1:0]  last_sw_q, last_sw_d;
  logic [SW_W-1:0]  data_q,    data_d;
  logic             valid_q,   valid_d;
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic             overrun_q, overrun_d;

  logic xfer;
  logic sw_changed;
  logic can_load;

  always_comb begin
    btn_meta_d = btn_i;
    btn_s_d    = btn_meta_q;
    sw_meta_d  = sw_i;
    sw_s_d     = sw_meta_q;
  end

  assign xfer       = valid_q & evt_ready_i;
  assign sw_changed = (sw_s_q != last_sw_q);
  // A load is allowed into an empty register, or into one being drained this cycle
  assign can_load   = ~valid_q | xfer;

  always_comb begin
    state_d   = state_q;
    db_cnt_d  = db_cnt_q;
    last_sw_d = last_sw_q;
    data_d    = data_q;
    valid_d   = valid_q;
    evt_cnt_d = evt_cnt_q;
    overrun_d = overrun_q;

    if (xfer) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        db_cnt_d = '0;
        if (btn_s_q) begin
          state_d = ST_PRESS;
        end
      end

      ST_PRESS: begin
        if (!btn_s_q) begin
          state_d  = ST_IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = ST_CAPTURE;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      ST_CAPTURE: begin
        db_cnt_d = '0;
        state_d  = ST_RELEASE;
        if (sw_changed) begin
          if (can_load) begin
            data_d    = sw_s_q;
            valid_d   = 1'b1;
            last_sw_d = sw_s_q;
            evt_cnt_d = evt_cnt_q + 1'b1;
          end else begin
            // last_sw is left alone so the next press retries this word
            overrun_d = 1'b1;
          end
        end
      end

      ST_RELEASE: begin
        if (btn_s_q) begin
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = ST_IDLE;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n_i) begin
    if (!rst_n_i) begin
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
      sw_meta_q  <= '0;
      sw_s_q     <= '0;
    end else begin
      btn_meta_q <= btn_meta_d;
      btn_s_q    <= btn_s_d;
      sw_meta_q  <= sw_meta_d;
      sw_s_q     <= sw_s_d;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      db_cnt_q  <= '0;
      last_sw_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      evt_cnt_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      db_cnt_q  <= db_cnt_d;
      last_sw_q <= last_sw_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      evt_cnt_q <= evt_cnt_d;
      overrun_q <= overrun_d;
    end
  end

  assign evt_data_o  = data_q;
  assign evt_valid_o = valid_q;
  assign evt_cnt_o   = evt_cnt_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sw_capture_ctrl.sv
// Directed bench for sw_capture_ctrl with a short debounce window; a second
// instance with a 2-bit event counter covers counter wrap.
module tb_sw_capture_ctrl;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst_n_w = 1'b0;
  logic [9:0] sw = '0;
  logic       btn = 1'b0;
  logic       ready = 1'b1;

  logic [9:0] evt_data;
  logic       evt_valid;
  logic [7:0] evt_cnt;
  logic       busy;
  logic       overrun;

  logic [9:0] w_data;
  logic       w_valid;
  logic [1:0] w_cnt;
  logic       w_busy;
  logic       w_overrun;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sw_capture_ctrl #(.DEBOUNCE_CYCLES(DB), .SW_W(10), .CNT_W(8)) dut (
    .clk_50m    (clk),
    .rst_n_i    (rst_n),
    .sw_i       (sw),
    .btn_i      (btn),
    .evt_data_o (evt_data),
    .evt_valid_o(evt_valid),
    .evt_ready_i(ready),
    .evt_cnt_o  (evt_cnt),
    .busy_o     (busy),
    .overrun_o  (overrun)
  );

  sw_capture_ctrl #(.DEBOUNCE_CYCLES(DB), .SW_W(10), .CNT_W(2)) dut_w (
    .clk_50m    (clk),
    .rst_n_i    (rst_n_w),
    .sw_i       (sw),
    .btn_i      (btn),
    .evt_data_o (w_data),
    .evt_valid_o(w_valid),
    .evt_ready_i(1'b1),
    .evt_cnt_o  (w_cnt),
    .busy_o     (w_busy),
    .overrun_o  (w_overrun)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold the button for 'hold' cycles, release, and wait (bounded) for busy to drop.
  task automatic press(input int hold, output bit saw_v, output bit timed_out);
    int n;
    saw_v = 1'b0;
    btn = 1'b1;
    repeat (hold) begin
      step(1);
      if (evt_valid) saw_v = 1'b1;
    end
    btn = 1'b0;
    n = 0;
    while ((busy || w_busy) && n < 40) begin
      step(1);
      if (evt_valid) saw_v = 1'b1;
      n++;
    end
    timed_out = busy | w_busy;
    step(2);
  endtask

  initial begin
    bit saw, to, any_v;

    // Reset state
    step(3);
    check("rst_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_data", {22'd0, evt_data}, 32'd0);
    check("rst_cnt", {24'd0, evt_cnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    sw = 10'h155;
    step(3);

    // Clean press: first sampled-high edge is E0, valid rises after E0+7
    btn = 1'b1;
    step(7);
    check("clean_pre_valid", {31'd0, evt_valid}, 32'd0);
    check("clean_busy_early", {31'd0, busy}, 32'd1);
    step(1);
    check("clean_valid", {31'd0, evt_valid}, 32'd1);
    check("clean_data", {22'd0, evt_data}, 32'h155);
    check("clean_cnt", {24'd0, evt_cnt}, 32'd1);
    step(1);
    check("clean_valid_1cyc", {31'd0, evt_valid}, 32'd0);
    check("clean_busy_held", {31'd0, busy}, 32'd1);
    step(11);
    check("clean_busy_hold20", {31'd0, busy}, 32'd1);
    btn = 1'b0;
    begin
      int n = 0;
      while (busy && n < 40) begin step(1); n++; end
    end
    check("clean_busy_release", {31'd0, busy}, 32'd0);

    // Bounce: never reaches capture
    any_v = 1'b0;
    btn = 1'b1; step(2);
    btn = 1'b0; step(1);
    btn = 1'b1; step(2);
    btn = 1'b0;
    repeat (12) begin
      step(1);
      if (evt_valid) any_v = 1'b1;
    end
    check("bounce_no_valid", {31'd0, any_v}, 32'd0);
    check("bounce_busy", {31'd0, busy}, 32'd0);
    check("bounce_cnt", {24'd0, evt_cnt}, 32'd1);

    // Switch changes alone never produce an event
    any_v = 1'b0;
    sw = 10'h2F0; step(4);
    sw = 10'h00F; step(4);
    sw = 10'h155; step(4);
    if (evt_valid) any_v = 1'b1;
    check("sw_only_no_valid", {31'd0, any_v}, 32'd0);
    check("sw_only_cnt", {24'd0, evt_cnt}, 32'd1);

    // Same switches as last capture: no event
    press(12, saw, to);
    check("same_timeout", {31'd0, to}, 32'd0);
    check("same_no_valid", {31'd0, saw}, 32'd0);
    check("same_cnt", {24'd0, evt_cnt}, 32'd1);

    // Backpressure and overrun
    ready = 1'b0;
    sw = 10'h0AA; step(3);
    press(12, saw, to);
    check("bp1_timeout", {31'd0, to}, 32'd0);
    check("bp1_valid", {31'd0, evt_valid}, 32'd1);
    check("bp1_data", {22'd0, evt_data}, 32'h0AA);
    check("bp1_cnt", {24'd0, evt_cnt}, 32'd2);
    check("bp1_overrun", {31'd0, overrun}, 32'd0);
    sw = 10'h3FF; step(3);
    press(12, saw, to);
    check("bp2_overrun", {31'd0, overrun}, 32'd1);
    check("bp2_valid", {31'd0, evt_valid}, 32'd1);
    check("bp2_data", {22'd0, evt_data}, 32'h0AA);
    check("bp2_cnt", {24'd0, evt_cnt}, 32'd2);
    ready = 1'b1;
    step(1);
    check("bp_drain", {31'd0, evt_valid}, 32'd0);
    press(12, saw, to);
    check("bp3_saw_valid", {31'd0, saw}, 32'd1);
    check("bp3_data", {22'd0, evt_data}, 32'h3FF);
    check("bp3_cnt", {24'd0, evt_cnt}, 32'd3);
    check("bp3_overrun_sticky", {31'd0, overrun}, 32'd1);

    // Reset during PRESS_WAIT
    btn = 1'b1;
    step(4);
    check("rstpw_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstpw_busy", {31'd0, busy}, 32'd0);
    check("rstpw_cnt", {24'd0, evt_cnt}, 32'd0);
    check("rstpw_overrun", {31'd0, overrun}, 32'd0);
    check("rstpw_data", {22'd0, evt_data}, 32'd0);
    btn = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);

    // Reset while an event is pending
    ready = 1'b0;
    sw = 10'h2AA; step(3);
    press(12, saw, to);
    check("rstv_valid_before", {31'd0, evt_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstv_valid", {31'd0, evt_valid}, 32'd0);
    check("rstv_data", {22'd0, evt_data}, 32'd0);
    check("rstv_cnt", {24'd0, evt_cnt}, 32'd0);
    step(2);
    rst_n = 1'b1;
    ready = 1'b1;
    sw = 10'h001; step(3);
    press(12, saw, to);
    check("post_rst_saw", {31'd0, saw}, 32'd1);
    check("post_rst_data", {22'd0, evt_data}, 32'h001);
    check("post_rst_cnt", {24'd0, evt_cnt}, 32'd1);

    // Counter wrap on the 2-bit instance
    rst_n_w = 1'b1;
    step(2);
    sw = 10'h011; step(3); press(12, saw, to);
    check("wrap_1", {30'd0, w_cnt}, 32'd1);
    sw = 10'h022; step(3); press(12, saw, to);
    check("wrap_2", {30'd0, w_cnt}, 32'd2);
    sw = 10'h033; step(3); press(12, saw, to);
    check("wrap_3", {30'd0, w_cnt}, 32'd3);
    sw = 10'h044; step(3); press(12, saw, to);
    check("wrap_0", {30'd0, w_cnt}, 32'd0);
    sw = 10'h055; step(3); press(12, saw, to);
    check("wrap_1b", {30'd0, w_cnt}, 32'd1);
    check("wrap_data", {22'd0, w_data}, 32'h055);
    check("wrap_timeout", {31'd0, to}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
